// File: rtl/dmac_pkg.sv
// Shared DMA controller types: AXI AW fields, burst/size encodings and the
// round-robin winner select used by both the write and read arbiters.
package dmac_pkg;

  localparam int N_CH_MAX   = 8;
  localparam int IDX_W      = 3;
  localparam int AXI_ADDR_W = 32;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } axi_size_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [3:0]            len;
    axi_size_e             size;
    axi_burst_e            burst;
  } axi_aw_t;

  // Scanning the full N_CH_MAX ring is equivalent to wrapping at N_CH because
  // request bits above N_CH-1 are always zero and ptr is always below N_CH.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CH_MAX-1:0] req,
                                               input logic [IDX_W-1:0]    ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    win = ptr;
    for (int i = N_CH_MAX - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/dmac_wr_arbiter_if.sv
// AXI3 write-path bundle (AW, W, B) between the write arbiter and the bus.
interface dmac_wr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid_o;
  logic [ADDR_W-1:0]   awaddr_o;
  logic [3:0]          awlen_o;
  logic [2:0]          awsize_o;
  logic [1:0]          awburst_o;
  logic                awvalid_o;
  logic                awready_i;
  logic [ID_W-1:0]     wid_o;
  logic [DATA_W-1:0]   wdata_o;
  logic [DATA_W/8-1:0] wstrb_o;
  logic                wlast_o;
  logic                wvalid_o;
  logic                wready_i;
  logic [ID_W-1:0]     bid_i;
  logic [1:0]          bresp_i;
  logic                bvalid_i;
  logic                bready_o;

  modport master (
    output awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    input  awready_i,
    output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
    input  wready_i,
    input  bid_i, bresp_i, bvalid_i,
    output bready_o
  );

  modport slave (
    input  awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
    output awready_i,
    input  wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
    output wready_i,
    output bid_i, bresp_i, bvalid_i,
    input  bready_o
  );
endinterface

// File: rtl/dmac_rr_picker.sv
// Combinational round-robin winner select: first set request at or after ptr.
module dmac_rr_picker
  import dmac_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             vld,
  output logic [PTR_W-1:0] grant
);

  logic [IDX_W-1:0] win;

  assign vld   = |req;
  assign win   = rr_pick(N_CH_MAX'(req), IDX_W'(ptr));
  assign grant = PTR_W'(win);

endmodule

// File: rtl/dmac_wr_arbiter.sv
// Round-robin arbiter sharing the AXI3 write path among N_CH DMA channel engines.
// Define DMAC_WR_ARB_FIXED_PRIO_EN for fixed priority (lowest channel index wins).
module dmac_wr_arbiter
  import dmac_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CH-1:0]                ch_awvalid_i,
  input  logic [N_CH-1:0][ADDR_W-1:0]    ch_awaddr_i,
  input  logic [N_CH-1:0][3:0]           ch_awlen_i,
  input  logic [N_CH-1:0][2:0]           ch_awsize_i,
  input  logic [N_CH-1:0][1:0]           ch_awburst_i,
  output logic [N_CH-1:0]                ch_awready_o,
  input  logic [N_CH-1:0]                ch_wvalid_i,
  input  logic [N_CH-1:0][DATA_W-1:0]    ch_wdata_i,
  input  logic [N_CH-1:0][DATA_W/8-1:0]  ch_wstrb_i,
  input  logic [N_CH-1:0]                ch_wlast_i,
  output logic [N_CH-1:0]                ch_wready_o,
  output logic [N_CH-1:0]                ch_bvalid_o,
  output logic [1:0]                     ch_bresp_o,
  input  logic [N_CH-1:0]                ch_bready_i,
  dmac_wr_arbiter_if.master              axi
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  axi_aw_t          aw_q, aw_d;
  logic [PTR_W-1:0] pick_ptr;
  logic [PTR_W-1:0] pick;
  logic             pick_vld;
  logic             bid_in_range;

`ifdef DMAC_WR_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  assign pick_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && pick_vld)
      rr_ptr_d = (pick == PTR_W'(N_CH - 1)) ? '0 : pick + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  dmac_rr_picker #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (ch_awvalid_i),
    .ptr   (pick_ptr),
    .vld   (pick_vld),
    .grant (pick)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    aw_d    = aw_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d    = pick;
          aw_d.addr  = AXI_ADDR_W'(ch_awaddr_i[pick]);
          aw_d.len   = ch_awlen_i[pick];
          aw_d.size  = axi_size_e'(ch_awsize_i[pick]);
          aw_d.burst = axi_burst_e'(ch_awburst_i[pick]);
          state_d    = ST_AW;
        end
      end
      ST_AW: begin
        if (axi.awready_i) state_d = ST_W;
      end
      ST_W: begin
        if (ch_wvalid_i[grant_q] && axi.wready_i && ch_wlast_i[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      aw_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      aw_q    <= aw_d;
    end
  end

  assign axi.awid_o    = ID_W'(grant_q);
  assign axi.awaddr_o  = ADDR_W'(aw_q.addr);
  assign axi.awlen_o   = aw_q.len;
  assign axi.awsize_o  = aw_q.size;
  assign axi.awburst_o = aw_q.burst;
  assign axi.awvalid_o = (state_q == ST_AW);
  assign axi.wid_o     = ID_W'(grant_q);

  // W is locked to the granted channel; all other channels see no ready.
  always_comb begin
    ch_awready_o  = '0;
    ch_wready_o   = '0;
    axi.wvalid_o  = 1'b0;
    axi.wdata_o   = '0;
    axi.wstrb_o   = '0;
    axi.wlast_o   = 1'b0;
    if (state_q == ST_AW) ch_awready_o[grant_q] = axi.awready_i;
    if (state_q == ST_W) begin
      axi.wvalid_o         = ch_wvalid_i[grant_q];
      axi.wdata_o          = ch_wdata_i[grant_q];
      axi.wstrb_o          = ch_wstrb_i[grant_q];
      axi.wlast_o          = ch_wlast_i[grant_q];
      ch_wready_o[grant_q] = axi.wready_i;
    end
  end

  // Responses carrying an ID outside the channel range are absorbed.
  assign bid_in_range = (axi.bid_i < ID_W'(N_CH));
  assign ch_bresp_o   = axi.bresp_i;

  always_comb begin
    ch_bvalid_o  = '0;
    axi.bready_o = 1'b1;
    if (bid_in_range) begin
      ch_bvalid_o[PTR_W'(axi.bid_i)] = axi.bvalid_i;
      axi.bready_o                   = ch_bready_i[PTR_W'(axi.bid_i)];
    end
  end

endmodule

// File: tb/tb_dmac_wr_arbiter.sv
// Scoreboard bench for dmac_wr_arbiter: expected AW/W traffic is queued at stimulus time
// and checked by a monitor on every bus handshake.
`timescale 1ns/1ps
module tb_dmac_wr_arbiter;
  import dmac_pkg::*;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_CH-1:0]                ch_awvalid_i;
  logic [N_CH-1:0][ADDR_W-1:0]    ch_awaddr_i;
  logic [N_CH-1:0][3:0]           ch_awlen_i;
  logic [N_CH-1:0][2:0]           ch_awsize_i;
  logic [N_CH-1:0][1:0]           ch_awburst_i;
  logic [N_CH-1:0]                ch_awready_o;
  logic [N_CH-1:0]                ch_wvalid_i;
  logic [N_CH-1:0][DATA_W-1:0]    ch_wdata_i;
  logic [N_CH-1:0][DATA_W/8-1:0]  ch_wstrb_i;
  logic [N_CH-1:0]                ch_wlast_i;
  logic [N_CH-1:0]                ch_wready_o;
  logic [N_CH-1:0]                ch_bvalid_o;
  logic [1:0]                     ch_bresp_o;
  logic [N_CH-1:0]                ch_bready_i;

  dmac_wr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  dmac_wr_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_awvalid_i (ch_awvalid_i),
    .ch_awaddr_i  (ch_awaddr_i),
    .ch_awlen_i   (ch_awlen_i),
    .ch_awsize_i  (ch_awsize_i),
    .ch_awburst_i (ch_awburst_i),
    .ch_awready_o (ch_awready_o),
    .ch_wvalid_i  (ch_wvalid_i),
    .ch_wdata_i   (ch_wdata_i),
    .ch_wstrb_i   (ch_wstrb_i),
    .ch_wlast_i   (ch_wlast_i),
    .ch_wready_o  (ch_wready_o),
    .ch_bvalid_o  (ch_bvalid_o),
    .ch_bresp_o   (ch_bresp_o),
    .ch_bready_i  (ch_bready_i),
    .axi          (axi)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
  } aw_exp_t;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              last;
  } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];

  int n_cmp  = 0;
  int n_err  = 0;
  int aw_cnt = 0;

  int              beat [N_CH];
  int              w_len[N_CH];
  logic [N_CH-1:0] w_act;
  logic [N_CH-1:0] aw_hold;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(int c, int b);
    return 32'hC000_0000 | (32'(c) << 16) | 32'(b);
  endfunction

  task automatic exp_burst(int c, logic [ADDR_W-1:0] addr, int len);
    aw_exp_t a;
    w_exp_t  w;
    a.id = ID_W'(c); a.addr = addr; a.len = 4'(len);
    aw_q.push_back(a);
    for (int b = 0; b <= len; b++) begin
      w.id = ID_W'(c); w.data = beat_data(c, b); w.last = (b == len);
      w_q.push_back(w);
    end
  endtask

  task automatic drive_w();
    for (int c = 0; c < N_CH; c++) begin
      ch_wvalid_i[c] = w_act[c];
      ch_wdata_i[c]  = beat_data(c, beat[c]);
      ch_wstrb_i[c]  = 4'hF;
      ch_wlast_i[c]  = (beat[c] == w_len[c]);
    end
  endtask

  task automatic set_req(int c, logic [ADDR_W-1:0] addr, int len);
    ch_awaddr_i[c]  = addr;
    ch_awlen_i[c]   = 4'(len);
    ch_awsize_i[c]  = 3'd2;
    ch_awburst_i[c] = 2'b01;
    w_len[c]        = len;
    w_act[c]        = 1'b1;
    beat[c]         = 0;
    drive_w();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (aw_q.size() == 0 && w_q.size() == 0 && !axi.awvalid_o && !axi.wvalid_o) break;
    end
    check("drain_left", 64'(aw_q.size() + w_q.size()), 0);
    @(posedge clk); #2;
  endtask

  // Channel engine model: drop AW request once accepted, advance W beats on handshake.
  initial begin : chan_model
    logic [N_CH-1:0] aw_fire, w_fire;
    forever begin
      @(negedge clk);
      aw_fire = ch_awvalid_i & ch_awready_o;
      w_fire  = ch_wvalid_i & ch_wready_o;
      @(posedge clk); #1;
      if (!rst) begin
        for (int c = 0; c < N_CH; c++) begin
          if (aw_fire[c] && !aw_hold[c]) ch_awvalid_i[c] = 1'b0;
          if (w_fire[c]) beat[c] = (beat[c] == w_len[c]) ? 0 : beat[c] + 1;
        end
        drive_w();
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    aw_exp_t a;
    w_exp_t  w;
    if (!rst) begin
      if (axi.awvalid_o && axi.awready_i) begin
        aw_cnt++;
        if (aw_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL aw_unexpected: got awid 0x%0h, expected no AW", axi.awid_o);
        end else begin
          a = aw_q.pop_front();
          check("awid",    64'(axi.awid_o),    64'(a.id));
          check("awaddr",  64'(axi.awaddr_o),  64'(a.addr));
          check("awlen",   64'(axi.awlen_o),   64'(a.len));
          check("awsize",  64'(axi.awsize_o),  64'd2);
          check("awburst", 64'(axi.awburst_o), 64'd1);
        end
      end
      if (axi.wvalid_o && axi.wready_i) begin
        if (w_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL w_unexpected: got wdata 0x%0h, expected no W beat", axi.wdata_o);
        end else begin
          w = w_q.pop_front();
          check("wid",   64'(axi.wid_o),   64'(w.id));
          check("wdata", 64'(axi.wdata_o), 64'(w.data));
          check("wlast", 64'(axi.wlast_o), 64'(w.last));
        end
      end
    end
  end

  initial begin : main
    int cnt0;
    int order[5];
    bit seen_w;
    ch_awvalid_i = '0; ch_awaddr_i = '0; ch_awlen_i = '0; ch_awsize_i = '0; ch_awburst_i = '0;
    ch_bready_i  = '0;
    w_act = '0; aw_hold = '0;
    for (int c = 0; c < N_CH; c++) begin beat[c] = 0; w_len[c] = 0; end
    drive_w();
    axi.awready_i = 1'b1; axi.wready_i = 1'b1;
    axi.bid_i = '0; axi.bresp_i = '0; axi.bvalid_i = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_awvalid",  64'(axi.awvalid_o), 0);
    check("rst_wvalid",   64'(axi.wvalid_o),  0);
    check("rst_wlast",    64'(axi.wlast_o),   0);
    check("rst_awaddr",   64'(axi.awaddr_o),  0);
    check("rst_ch_awrdy", 64'(ch_awready_o),  0);
    check("rst_ch_wrdy",  64'(ch_wready_o),   0);
    @(negedge clk); rst = 1'b0;

    // Single request from ch2, checking one-cycle grant latency.
    @(posedge clk); #2;
    set_req(2, 32'h2000, 3);
    exp_burst(2, 32'h2000, 3);
    ch_awvalid_i[2] = 1'b1;
    @(negedge clk);
    check("grant_lat_before", 64'(axi.awvalid_o), 0);
    @(negedge clk);
    check("grant_lat_after", 64'(axi.awvalid_o), 1);
    check("grant_awid",      64'(axi.awid_o),    2);
    wait_drain();
    w_act = '0; drive_w();

    // All channels request continuously from reset.
    rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
`ifdef DMAC_WR_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int c = 0; c < N_CH; c++) set_req(c, 32'(32'h100 * (c + 1)), 0);
    for (int k = 0; k < 5; k++) exp_burst(order[k], 32'(32'h100 * (order[k] + 1)), 0);
    cnt0 = aw_cnt;
    aw_hold = '1;
    ch_awvalid_i = '1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (aw_cnt >= cnt0 + 5) break;
    end
    ch_awvalid_i = '0;
    aw_hold = '0;
    check("cont_aw_count", 64'(aw_cnt - cnt0), 5);
    wait_drain();
    w_act = '0; drive_w();

    // AW backpressure: captured fields must hold while ch1 keeps changing its address.
    axi.awready_i = 1'b0;
    set_req(1, 32'h1100, 1);
    exp_burst(1, 32'h1100, 1);
    ch_awvalid_i[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_awvalid", 64'(axi.awvalid_o),  1);
      check("bp_awaddr",  64'(axi.awaddr_o),   64'h1100);
      check("bp_awready", 64'(ch_awready_o[1]), 0);
      @(posedge clk); #2;
      ch_awaddr_i[1] = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
    end
    @(posedge clk); #2;
    axi.awready_i = 1'b1;
    @(negedge clk);
    check("bp_awready_pulse", 64'(ch_awready_o[1]), 1);
    @(negedge clk);
    check("bp_awready_after", 64'(ch_awready_o[1]), 0);
    wait_drain();
    w_act = '0; drive_w();

    // W isolation: ch3 offers data while ch0 owns the W channel.
    set_req(0, 32'h0040, 2);
    w_act[3] = 1'b1; w_len[3] = 0; beat[3] = 0; drive_w();
    exp_burst(0, 32'h0040, 2);
    ch_awvalid_i[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi.wvalid_o) check("iso_ch3_wready", 64'(ch_wready_o[3]), 0);
    end
    wait_drain();
    w_act = '0; drive_w();

    // B routing.
    axi.bid_i = 4'd1; axi.bresp_i = 2'b10; axi.bvalid_i = 1'b1; ch_bready_i = 4'b0010;
    #1;
    check("b1_bvalid", 64'(ch_bvalid_o),  64'b0010);
    check("b1_bready", 64'(axi.bready_o), 1);
    check("b1_bresp",  64'(ch_bresp_o),   2);
    ch_bready_i = 4'b1101;
    #1;
    check("b1_bready_low", 64'(axi.bready_o), 0);
    axi.bid_i = 4'd3; ch_bready_i = 4'b1000;
    #1;
    check("b3_bvalid", 64'(ch_bvalid_o),  64'b1000);
    check("b3_bready", 64'(axi.bready_o), 1);
    axi.bid_i = 4'd7; ch_bready_i = 4'b0000;
    #1;
    check("b7_bvalid", 64'(ch_bvalid_o),  0);
    check("b7_bready", 64'(axi.bready_o), 1);
    axi.bvalid_i = 1'b0; axi.bid_i = '0; ch_bready_i = '0;
    @(posedge clk); #2;

    // Reset in the middle of ch1's W phase; rr_ptr points past ch1 beforehand.
    set_req(1, 32'h3000, 7);
    exp_burst(1, 32'h3000, 7);
    ch_awvalid_i[1] = 1'b1;
    seen_w = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.wvalid_o) begin seen_w = 1'b1; break; end
    end
    check("rst_reach_w", 64'(seen_w), 1);
    #3 rst = 1'b1;
    #1;
    check("midrst_wvalid",   64'(axi.wvalid_o),  0);
    check("midrst_awvalid",  64'(axi.awvalid_o), 0);
    check("midrst_wlast",    64'(axi.wlast_o),   0);
    check("midrst_ch_wrdy",  64'(ch_wready_o),   0);
    aw_q.delete(); w_q.delete();
    ch_awvalid_i = '0; w_act = '0;
    for (int c = 0; c < N_CH; c++) beat[c] = 0;
    drive_w();
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    set_req(0, 32'h4000, 1);
    set_req(2, 32'h5000, 1);
    exp_burst(0, 32'h4000, 1);
    exp_burst(2, 32'h5000, 1);
    ch_awvalid_i[0] = 1'b1; ch_awvalid_i[2] = 1'b1;
    wait_drain();
    w_act = '0; drive_w();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
